gate_mac_seq: RTL and testbench
===============================

GATE_MAC_SEQ -- requirements
Module: gate_mac_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning signed fixed-point word width.
REQ-002 SHALL have parameter FRACT_WIDTH, default 4, meaning fractional bits of every data word.
REQ-003 SHALL have parameter N_X, default 4, meaning number of input-vector elements (x/W pairs).
REQ-004 SHALL have parameter N_H, default 4, meaning number of hidden-state elements (h/U pairs).
REQ-005 SHALL have parameter ACC_WIDTH, default 24, meaning internal accumulator width.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, meaning operand bundle valid.
REQ-009 SHALL have port in_ready, output, 1, meaning block accepts a bundle this cycle.
REQ-010 SHALL have port x_vec, input, N_X*DATA_WIDTH, meaning packed x elements, element i at bits [i*DW +: DW].
REQ-011 SHALL have port w_vec, input, N_X*DATA_WIDTH, meaning packed W weights, same packing.
REQ-012 SHALL have port h_vec, input, N_H*DATA_WIDTH, meaning packed h_in elements.
REQ-013 SHALL have port u_vec, input, N_H*DATA_WIDTH, meaning packed U weights.
REQ-014 SHALL have port b, input, DATA_WIDTH, meaning bias.
REQ-015 SHALL have port out, output, DATA_WIDTH, meaning result W·x + U·h + b.
REQ-016 SHALL have port sat_flag, output, 1, meaning out was clamped.
REQ-017 SHALL have port out_valid, output, 1, meaning out/sat_flag valid.
REQ-018 SHALL have port out_ready, input, 1, meaning consumer accepts result.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, BIAS, DONE.
REQ-020 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-021 SHALL, on in_valid&&in_ready, register all vectors and b, clear accumulator and term index, enter MAC.
REQ-022 SHALL in MAC add one full-precision 2*DW-bit signed product per cycle: index 0..N_X-1 uses x[i]*w[i], index N_X..N_X+N_H-1 uses h[j]*u[j].
REQ-023 SHALL enter BIAS after the edge processing the final index (N_X+N_H MAC cycles).
REQ-024 SHALL in BIAS add b sign-extended and shifted left by FRACT_WIDTH, arithmetic-shift right by FRACT_WIDTH (truncate toward minus infinity), clamp to [-2^(DW-1), 2^(DW-1)-1], register out and sat_flag, enter DONE.
REQ-025 SHALL produce out_valid exactly N_X+N_H+1 clock edges after the accepting edge.
REQ-026 SHALL hold out, sat_flag, out_valid stable in DONE until out_ready=1; on out_valid&&out_ready return to IDLE (out_valid low next cycle).
REQ-027 SHALL ignore in_valid outside IDLE; no overlap of bundles.
REQ-028 SHALL never wrap the accumulator; ACC_WIDTH < 2*DW+clog2(N_X+N_H+1)+FRACT_WIDTH SHALL be an elaboration error.
REQ-029 SHALL keep out and sat_flag at last values after handshake until next result.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, force IDLE, accumulator 0, index 0, out=0, sat_flag=0, out_valid=0, in_ready=1 next cycle.
REQ-031 SHALL abandon any in-flight computation on reset in any state with no result emitted; rst dominates simultaneous in_valid.

Structure
REQ-032 SHALL place FSM state enum and accumulator-width check function in shared package gate_pkg.
REQ-033 SHALL implement the shift/truncate/clamp as one sub-module q_round_sat (ACC_WIDTH in, DATA_WIDTH out plus sat flag), reusable by later gate blocks.

Verification (defaults, Q4.4)
REQ-034 SHALL test: all x=0x10, w=0x08, h=0x10, u=0x08, b=0x00 -> out=0x40, sat_flag=0, out_valid 9 edges after accept.
REQ-035 SHALL test: all x,h=0xF0, w,u=0x08, b=0x10 -> out=0xD0, sat_flag=0.
REQ-036 SHALL test: all operands 0x7F, b=0x7F -> out=0x7F, sat_flag=1; all x,h=0x80, w,u=0x7F -> out=0x80, sat_flag=1.
REQ-037 SHALL test truncation: all x,h=0x01, w,u=0x01, b=0 -> out=0x00; x,h=0xFF instead -> out=0xFF.
REQ-038 SHALL test backpressure: out_ready low 5 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored; result consumed on first out_ready=1 cycle.
REQ-039 SHALL test reset at 3rd MAC cycle -> next cycle IDLE, out=0, out_valid=0, in_ready=1; following bundle computes correctly.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared FSM state type and accumulator sizing helper for gate blocks.
// Revision    : 1.0
// ============================================================================
package gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } gate_state_t;

    // Smallest accumulator that holds n_terms full products plus the bias without wrapping.
    function automatic int acc_width_min(input int dw, input int fw, input int n_terms);
        return 2 * dw + $clog2(n_terms + 1) + fw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : q_round_sat
// Description : Drops FRACT_WIDTH fraction bits (floor) and saturates to DATA_WIDTH.
// Revision    : 1.0
// ============================================================================
module q_round_sat #(
    parameter int ACC_WIDTH   = 24,
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 4
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic        [DATA_WIDTH-1:0] data_o,
    output logic                         sat_o
);

    localparam logic signed [ACC_WIDTH-1:0] c_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] w_shift;

    assign w_shift = acc_i >>> FRACT_WIDTH;

    always_comb begin
        data_o = w_shift[DATA_WIDTH-1:0];
        sat_o  = 1'b0;
        if (w_shift > c_max) begin
            data_o = c_max[DATA_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (w_shift < c_min) begin
            data_o = c_min[DATA_WIDTH-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gate_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate_mac_seq
// Description : Sequential one-product-per-cycle W.x + U.h + b with Q-format saturation.
// Revision    : 1.0
// ============================================================================
module gate_mac_seq
    import gate_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 4,
    parameter int N_X         = 4,
    parameter int N_H         = 4,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_X*DATA_WIDTH-1:0]  x_vec,
    input  logic [N_X*DATA_WIDTH-1:0]  w_vec,
    input  logic [N_H*DATA_WIDTH-1:0]  h_vec,
    input  logic [N_H*DATA_WIDTH-1:0]  u_vec,
    input  logic [DATA_WIDTH-1:0]      b,
    output logic [DATA_WIDTH-1:0]      out,
    output logic                       sat_flag,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int c_n_terms = N_X + N_H;
    localparam int c_idx_w   = $clog2(c_n_terms + 1);
    localparam int c_depth   = 1 << c_idx_w;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n_terms - 1);

    if (ACC_WIDTH < acc_width_min(DATA_WIDTH, FRACT_WIDTH, c_n_terms)) begin : g_acc_width_err
        $error("gate_mac_seq: ACC_WIDTH too small, accumulator could wrap");
    end

    gate_state_t                  state_q, state_d;
    logic [c_idx_w-1:0]           idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [N_X*DATA_WIDTH-1:0]    x_q, w_q;
    logic [N_H*DATA_WIDTH-1:0]    h_q, u_q;
    logic [DATA_WIDTH-1:0]        b_q;
    logic [DATA_WIDTH-1:0]        out_q, out_d;
    logic                         sat_q, sat_d;
    logic                         w_accept;

    logic signed [DATA_WIDTH-1:0]   w_opa [c_depth];
    logic signed [DATA_WIDTH-1:0]   w_opb [c_depth];
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_bias_ext;
    logic signed [ACC_WIDTH-1:0]    w_biased;
    logic [DATA_WIDTH-1:0]          w_rs_data;
    logic                           w_rs_sat;

    // Flatten x/W then h/U into one operand table indexed by the term counter.
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_ops
        if (gi < N_X) begin : g_x
            assign w_opa[gi] = x_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_opb[gi] = w_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (gi < c_n_terms) begin : g_h
            assign w_opa[gi] = h_q[(gi-N_X)*DATA_WIDTH +: DATA_WIDTH];
            assign w_opb[gi] = u_q[(gi-N_X)*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_opa[gi] = '0;
            assign w_opb[gi] = '0;
        end
    end

    assign w_prod     = w_opa[idx_q] * w_opb[idx_q];
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_bias_ext = $signed({{(ACC_WIDTH-DATA_WIDTH){b_q[DATA_WIDTH-1]}}, b_q}) <<< FRACT_WIDTH;
    assign w_biased   = acc_q + w_bias_ext;

    q_round_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_round_sat (
        .acc_i  (w_biased),
        .data_o (w_rs_data),
        .sat_o  (w_rs_sat)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_d     = out_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + w_prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == c_last_idx) state_d = ST_BIAS;
            end
            ST_BIAS: begin
                out_d   = w_rs_data;
                sat_d   = w_rs_sat;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            u_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
            if (w_accept) begin
                x_q <= x_vec;
                w_q <= w_vec;
                h_q <= h_vec;
                u_q <= u_vec;
                b_q <= b;
            end
        end
    end

    assign out      = out_q;
    assign sat_flag = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_mac_seq
// Description : Directed and random checks of gate_mac_seq against an arithmetic model.
// Revision    : 1.0
// ============================================================================
module tb_gate_mac_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, sat_flag;
    logic [31:0] x_vec, w_vec, h_vec, u_vec;
    logic [7:0]  b, dout;

    logic [7:0]  xa [4];
    logic [7:0]  wa [4];
    logic [7:0]  ha [4];
    logic [7:0]  ua [4];
    logic [7:0]  ba;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gate_mac_seq #(
        .DATA_WIDTH  (8),
        .FRACT_WIDTH (4),
        .N_X         (4),
        .N_H         (4),
        .ACC_WIDTH   (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_vec     (x_vec),
        .w_vec     (w_vec),
        .h_vec     (h_vec),
        .u_vec     (u_vec),
        .b         (b),
        .out       (dout),
        .sat_flag  (sat_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        x_vec = {xa[3], xa[2], xa[1], xa[0]};
        w_vec = {wa[3], wa[2], wa[1], wa[0]};
        h_vec = {ha[3], ha[2], ha[1], ha[0]};
        u_vec = {ua[3], ua[2], ua[1], ua[0]};
        b     = ba;
    endtask

    task automatic fill(input logic [7:0] xv, input logic [7:0] wv, input logic [7:0] hv,
                        input logic [7:0] uv, input logic [7:0] bv);
        for (int i = 0; i < 4; i++) begin
            xa[i] = xv; wa[i] = wv; ha[i] = hv; ua[i] = uv;
        end
        ba = bv;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h7F;
        if (r == 1) return 8'h80;
        return 8'($urandom);
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            xa[i] = pick(); wa[i] = pick(); ha[i] = pick(); ua[i] = pick();
        end
        ba = pick();
    endtask

    // Real-valued view in units of 2^-8: sum of products plus bias, floor to 2^-4, clamp.
    function automatic void model(output logic [7:0] o, output logic s);
        longint sum, q;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += longint'($signed(xa[i])) * longint'($signed(wa[i]));
            sum += longint'($signed(ha[i])) * longint'($signed(ua[i]));
        end
        sum += longint'($signed(ba)) * 16;
        q = sum / 16;
        if ((sum % 16 != 0) && (sum < 0)) q = q - 1;
        s = 1'b0;
        if (q > 127) begin
            o = 8'h7F; s = 1'b1;
        end else if (q < -128) begin
            o = 8'h80; s = 1'b1;
        end else begin
            o = q[7:0];
        end
    endfunction

    task automatic run_bundle(input string tag, input bit use_model, input logic [7:0] exp_o,
                              input logic exp_s, input int hold);
        logic [7:0] eo;
        logic       es;
        int         lat;
        if (use_model) model(eo, es);
        else begin
            eo = exp_o; es = exp_s;
        end
        pack();
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " out"}, 32'(dout), 32'(eo));
        check({tag, " sat"}, 32'(sat_flag), 32'(es));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, " hold_out"}, 32'(dout), 32'(eo));
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " out_kept"}, 32'(dout), 32'(eo));
        check({tag, " sat_kept"}, 32'(sat_flag), 32'(es));
        if (hold > 0) begin
            @(posedge clk); #1;
            check({tag, " ignored_bundle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        fill(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        pack();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(dout), 32'd0);
        check("reset sat", 32'(sat_flag), 32'd0);

        fill(8'h10, 8'h08, 8'h10, 8'h08, 8'h00); run_bundle("basic", 0, 8'h40, 1'b0, 0);
        fill(8'hF0, 8'h08, 8'hF0, 8'h08, 8'h10); run_bundle("negative", 0, 8'hD0, 1'b0, 1);
        fill(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F); run_bundle("sat_pos", 0, 8'h7F, 1'b1, 0);
        fill(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00); run_bundle("sat_neg", 0, 8'h80, 1'b1, 2);
        fill(8'h01, 8'h01, 8'h01, 8'h01, 8'h00); run_bundle("trunc_pos", 0, 8'h00, 1'b0, 0);
        fill(8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00); run_bundle("trunc_neg", 0, 8'hFF, 1'b0, 0);
        fill(8'h30, 8'h08, 8'hE0, 8'h08, 8'h05); run_bundle("backpressure", 1, 8'h00, 1'b0, 5);

        // Reset lands on the third MAC cycle of an accepted bundle.
        rand_ops();
        pack();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset out", 32'(dout), 32'd0);
        check("midreset sat", 32'(sat_flag), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("midreset no_result", 32'(seen), 32'd0);
        rand_ops(); run_bundle("post_reset", 1, 8'h00, 1'b0, 0);

        for (int t = 0; t < 24; t++) begin
            rand_ops();
            run_bundle("random", 1, 8'h00, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
